// File: rtl/game_state_decoder.sv
// game_state_decoder
//   Consumer side of the game FSM state interface. Registers the 3-bit state
//   code (driven by the FSM on the falling edge) on the rising edge. It then
//   turns that code into per-frame enables and pulses for the object and
//   render modules. Frame pacing comes from the VGA frame tick.
//
// Ports:
//   i_clk            system clock, all logic on posedge
//   i_reset          synchronous active-high reset
//   i_state_code[2:0] FSM state (000 START, 001 PLAYING, 010 PAUSE,
//                    011 RESET, 100 GAMEOVER, 101-111 invalid)
//   i_frame_tick     one-clk pulse per video frame
//   o_cur_state[2:0] last valid state code accepted
//   o_move_en        one-clk pulse: object movement step
//   o_spawn_en       one-clk pulse: spawn new object
//   o_clear_pulse    one-clk pulse on entry into RESET
//   o_pause_blink    pause indicator blink level
//   o_gameover_done  game-over hold elapsed (level)
//   o_code_error     invalid code sampled this cycle
module game_state_decoder #(
  parameter int unsigned SPAWN_FRAMES    = 60,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned GAMEOVER_FRAMES = 120
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_state_code,
  input  logic       i_frame_tick,
  output logic [2:0] o_cur_state,
  output logic       o_move_en,
  output logic       o_spawn_en,
  output logic       o_clear_pulse,
  output logic       o_pause_blink,
  output logic       o_gameover_done,
  output logic       o_code_error
);

  typedef enum logic [2:0] {
    ST_START    = 3'b000,
    ST_PLAYING  = 3'b001,
    ST_PAUSE    = 3'b010,
    ST_RESET    = 3'b011,
    ST_GAMEOVER = 3'b100
  } state_e;

  localparam int unsigned SW = ($clog2(SPAWN_FRAMES + 1) < 1) ? 1 : $clog2(SPAWN_FRAMES + 1);
  localparam int unsigned BW = ($clog2(BLINK_FRAMES + 1) < 1) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam int unsigned GW = ($clog2(GAMEOVER_FRAMES + 1) < 1) ? 1 : $clog2(GAMEOVER_FRAMES + 1);

  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_FRAMES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [GW-1:0] GO_MAX     = GW'(GAMEOVER_FRAMES);

  state_e        r_cur_state;
  logic          r_move_en;
  logic          r_spawn_en;
  logic          r_clear_pulse;
  logic          r_pause_blink;
  logic          r_gameover_done;
  logic          r_code_error;
  logic [SW-1:0] r_spawn_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic [GW-1:0] r_go_cnt;

  logic          w_valid;
  state_e        w_state;
  state_e        w_cur_state_n;
  logic          w_move_en_n;
  logic          w_spawn_en_n;
  logic          w_clear_pulse_n;
  logic          w_pause_blink_n;
  logic          w_gameover_done_n;
  logic          w_code_error_n;
  logic [SW-1:0] w_spawn_cnt_n;
  logic [BW-1:0] w_blink_cnt_n;
  logic [GW-1:0] w_go_cnt_n;

  assign w_valid = (i_state_code <= 3'b100);
  assign w_state = state_e'(i_state_code);

  // Register stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cur_state     <= ST_RESET;
      r_move_en       <= 1'b0;
      r_spawn_en      <= 1'b0;
      r_clear_pulse   <= 1'b0;
      r_pause_blink   <= 1'b0;
      r_gameover_done <= 1'b0;
      r_code_error    <= 1'b0;
      r_spawn_cnt     <= '0;
      r_blink_cnt     <= '0;
      r_go_cnt        <= '0;
    end else begin
      r_cur_state     <= w_cur_state_n;
      r_move_en       <= w_move_en_n;
      r_spawn_en      <= w_spawn_en_n;
      r_clear_pulse   <= w_clear_pulse_n;
      r_pause_blink   <= w_pause_blink_n;
      r_gameover_done <= w_gameover_done_n;
      r_code_error    <= w_code_error_n;
      r_spawn_cnt     <= w_spawn_cnt_n;
      r_blink_cnt     <= w_blink_cnt_n;
      r_go_cnt        <= w_go_cnt_n;
    end
  end

  // Next-value logic. All decisions use the newly sampled state, so a state
  // change and a frame tick in the same cycle are judged against the new state.
  always_comb begin
    // Invalid code: hold state, counters and levels; drop the pulses.
    w_cur_state_n     = r_cur_state;
    w_move_en_n       = 1'b0;
    w_spawn_en_n      = 1'b0;
    w_clear_pulse_n   = 1'b0;
    w_pause_blink_n   = r_pause_blink;
    w_gameover_done_n = r_gameover_done;
    w_code_error_n    = ~w_valid;
    w_spawn_cnt_n     = r_spawn_cnt;
    w_blink_cnt_n     = r_blink_cnt;
    w_go_cnt_n        = r_go_cnt;

    if (w_valid) begin
      w_cur_state_n   = w_state;
      w_clear_pulse_n = (w_state == ST_RESET) && (r_cur_state != ST_RESET);
      w_move_en_n     = (w_state == ST_PLAYING) && i_frame_tick;

      // Spawn cadence: hold through PAUSE so play resumes mid-count.
      case (w_state)
        ST_PLAYING: begin
          if (i_frame_tick) begin
            if (r_spawn_cnt == SPAWN_LAST) begin
              w_spawn_cnt_n = '0;
              w_spawn_en_n  = 1'b1;
            end else begin
              w_spawn_cnt_n = r_spawn_cnt + SW'(1);
            end
          end
        end
        ST_PAUSE: w_spawn_cnt_n = r_spawn_cnt;
        default:  w_spawn_cnt_n = '0;
      endcase

      // Pause blink: entry wins over a coincident tick so the indicator
      // shows at once and the first half-period is a full one.
      if (w_state == ST_PAUSE) begin
        if (r_cur_state != ST_PAUSE) begin
          w_blink_cnt_n   = '0;
          w_pause_blink_n = 1'b1;
        end else if (i_frame_tick) begin
          if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_n   = '0;
            w_pause_blink_n = ~r_pause_blink;
          end else begin
            w_blink_cnt_n = r_blink_cnt + BW'(1);
          end
        end
      end else begin
        w_blink_cnt_n   = '0;
        w_pause_blink_n = 1'b0;
      end

      // Game-over hold: saturating count, done tracks count == limit.
      if (w_state == ST_GAMEOVER) begin
        if (i_frame_tick && (r_go_cnt < GO_MAX)) begin
          w_go_cnt_n = r_go_cnt + GW'(1);
        end
        w_gameover_done_n = (w_go_cnt_n >= GO_MAX);
      end else begin
        w_go_cnt_n        = '0;
        w_gameover_done_n = 1'b0;
      end
    end
  end

  // Output drive
  always_comb begin
    o_cur_state     = r_cur_state;
    o_move_en       = r_move_en;
    o_spawn_en      = r_spawn_en;
    o_clear_pulse   = r_clear_pulse;
    o_pause_blink   = r_pause_blink;
    o_gameover_done = r_gameover_done;
    o_code_error    = r_code_error;
  end

endmodule
